dump_controller: RTL and testbench

Sequences the end-of-program state dump of the RISC-V core: walks the register file and, optionally, data memory, formatting every word as an ASCII binary line and feeding bytes to `uart_tx` through a valid/ready handshake. Sits between the WB/MEM-stage storage read ports and `uart_tx`. It replaces ad-hoc combinational byte selection with an explicit FSM that owns the read ports during the dump.

---
 rtl/dump_controller.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_dump_controller.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dump_controller.sv
// -----------------------------------------------------------------------------
// dump_controller
//
// Runs the end-of-program state dump. It walks the register file and, when
// DUMP_MEM_EN is defined, the data memory too. Each word goes out as one ASCII
// line of '0'/'1' characters, MSB first, followed by CR LF. Bytes are handed
// to uart_tx over a valid/ready handshake. While a dump is running, this block
// drives the storage read ports.
//
// Build option:
//   DUMP_MEM_EN  defined   -> "REGS:" section followed by "MEM:" section
//                undefined -> "REGS:" section only; mem_rd_addr tied to 0,
//                             mem_rd_data ignored
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         level request; one dump per assertion
//   reg_rd_addr   register-file read address (combinational read)
//   reg_rd_data   register-file read data for reg_rd_addr, same cycle
//   mem_rd_addr   data-memory read address (synchronous read)
//   mem_rd_data   data-memory read data, valid one cycle after the address
//   tx_byte       byte presented to uart_tx
//   tx_valid      tx_byte is valid; transfer when tx_valid && tx_ready
//   tx_ready      uart_tx accepts a byte
//   busy          dump in progress
//   done          dump complete; held until start drops
// -----------------------------------------------------------------------------
module dump_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_COUNT      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_WORDS      = 32,
  parameter int MEM_ADDR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic [DATA_WIDTH-1:0]     reg_rd_data,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  output logic [7:0]                tx_byte,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      done
);

  // The line counter spans the data bits plus CR and LF (0..DATA_WIDTH+1).
  localparam int CNT_W     = $clog2(DATA_WIDTH + 2);
  localparam int MAX_WORDS = (REG_COUNT > MEM_WORDS) ? REG_COUNT : MEM_WORDS;
  localparam int IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CR_POS   = CNT_W'(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(REG_COUNT - 1);

  localparam logic [2:0] REGS_HDR_LAST = 3'd6;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_1  = 8'h31;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [3:0] {
    IDLE,
    HDR_REGS,
    REG_BITS,
    REG_EOL,
`ifdef DUMP_MEM_EN
    HDR_MEM,
    MEM_FETCH,
    MEM_BITS,
    MEM_EOL,
`endif
    DONE
  } state_t;

  // "REGS:\r\n"
  function automatic logic [7:0] regs_hdr(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h52;
      3'd1:    return 8'h45;
      3'd2:    return 8'h47;
      3'd3:    return 8'h53;
      3'd4:    return 8'h3A;
      3'd5:    return CHAR_CR;
      3'd6:    return CHAR_LF;
      default: return 8'h00;
    endcase
  endfunction

`ifdef DUMP_MEM_EN
  localparam logic [IDX_W-1:0] LAST_MEM     = IDX_W'(MEM_WORDS - 1);
  localparam logic [2:0]       MEM_HDR_LAST = 3'd5;

  // "MEM:\r\n"
  function automatic logic [7:0] mem_hdr(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h4D;
      3'd1:    return 8'h45;
      3'd2:    return 8'h4D;
      3'd3:    return 8'h3A;
      3'd4:    return CHAR_CR;
      3'd5:    return CHAR_LF;
      default: return 8'h00;
    endcase
  endfunction
`endif

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;      // byte within the current line
  logic [2:0]            hdr, hdr_next;      // byte within a header
  logic [IDX_W-1:0]      idx, idx_next;      // register / memory word index
  logic [DATA_WIDTH-1:0] shreg, shreg_next;  // word being serialised
  logic [DATA_WIDTH-1:0] word_cur;

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hdr   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      hdr   <= hdr_next;
      idx   <= idx_next;
      shreg <= shreg_next;
    end
  end

  // The first bit of a word is taken straight from the read port. The full
  // word is then loaded into the shift register when that first bit is
  // transferred. The read address is held for the whole line, so the port
  // output stays stable if the first bit is stalled. This keeps reg_rd_addr
  // and mem_rd_addr equal to the current index and avoids any look-ahead
  // address.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and infers a latch.
    state_next  = state;
    cnt_next    = cnt;
    hdr_next    = hdr;
    idx_next    = idx;
    shreg_next  = shreg;
    word_cur    = shreg;
    tx_byte     = 8'h00;
    tx_valid    = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    reg_rd_addr = '0;
`ifdef DUMP_MEM_EN
    mem_rd_addr = '0;
`endif

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = HDR_REGS;
          hdr_next   = '0;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end

      HDR_REGS: begin
        tx_valid = 1'b1;
        tx_byte  = regs_hdr(hdr);
        if (tx_ready) begin
          if (hdr == REGS_HDR_LAST) begin
            state_next = REG_BITS;
            hdr_next   = '0;
            cnt_next   = '0;
            idx_next   = '0;
          end else begin
            hdr_next = hdr + 3'd1;
          end
        end
      end

      REG_BITS: begin
        reg_rd_addr = REG_ADDR_WIDTH'(idx);
        if (cnt == '0) word_cur = reg_rd_data;
        tx_valid = 1'b1;
        tx_byte  = word_cur[DATA_WIDTH-1] ? CHAR_1 : CHAR_0;
        if (tx_ready) begin
          shreg_next = {word_cur[DATA_WIDTH-2:0], 1'b0};
          cnt_next   = cnt + CNT_W'(1);
          if (cnt == LAST_BIT) state_next = REG_EOL;
        end
      end

      REG_EOL: begin
        reg_rd_addr = REG_ADDR_WIDTH'(idx);
        tx_valid    = 1'b1;
        tx_byte     = (cnt == CR_POS) ? CHAR_CR : CHAR_LF;
        if (tx_ready) begin
          if (cnt == CR_POS) begin
            cnt_next = cnt + CNT_W'(1);
          end else begin
            cnt_next = '0;
            if (idx != LAST_REG) begin
              idx_next   = idx + IDX_W'(1);
              state_next = REG_BITS;
            end else begin
`ifdef DUMP_MEM_EN
              state_next = HDR_MEM;
              hdr_next   = '0;
              idx_next   = '0;
`else
              state_next = DONE;
`endif
            end
          end
        end
      end

`ifdef DUMP_MEM_EN
      HDR_MEM: begin
        tx_valid = 1'b1;
        tx_byte  = mem_hdr(hdr);
        if (tx_ready) begin
          if (hdr == MEM_HDR_LAST) begin
            state_next = MEM_FETCH;
            hdr_next   = '0;
            cnt_next   = '0;
            idx_next   = '0;
          end else begin
            hdr_next = hdr + 3'd1;
          end
        end
      end

      // One bubble cycle so the synchronous memory can return the word.
      MEM_FETCH: begin
        mem_rd_addr = MEM_ADDR_WIDTH'(idx);
        state_next  = MEM_BITS;
      end

      MEM_BITS: begin
        mem_rd_addr = MEM_ADDR_WIDTH'(idx);
        if (cnt == '0) word_cur = mem_rd_data;
        tx_valid = 1'b1;
        tx_byte  = word_cur[DATA_WIDTH-1] ? CHAR_1 : CHAR_0;
        if (tx_ready) begin
          shreg_next = {word_cur[DATA_WIDTH-2:0], 1'b0};
          cnt_next   = cnt + CNT_W'(1);
          if (cnt == LAST_BIT) state_next = MEM_EOL;
        end
      end

      MEM_EOL: begin
        mem_rd_addr = MEM_ADDR_WIDTH'(idx);
        tx_valid    = 1'b1;
        tx_byte     = (cnt == CR_POS) ? CHAR_CR : CHAR_LF;
        if (tx_ready) begin
          if (cnt == CR_POS) begin
            cnt_next = cnt + CNT_W'(1);
          end else begin
            cnt_next = '0;
            if (idx != LAST_MEM) begin
              idx_next   = idx + IDX_W'(1);
              state_next = MEM_FETCH;
            end else begin
              state_next = DONE;
            end
          end
        end
      end
`endif

      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!start) state_next = IDLE;
      end

      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

`ifndef DUMP_MEM_EN
  // The memory read data is not used when the memory section is compiled out.
  logic unused_mem_rd_data;
  assign unused_mem_rd_data = ^mem_rd_data;
  assign mem_rd_addr        = '0;
`endif

endmodule

// File: tb/tb_dump_controller.sv
module tb_dump_controller;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int MEM_WORDS      = 32;
  localparam int MEM_ADDR_WIDTH = 6;
  localparam int LINE_BYTES     = DATA_WIDTH + 2;
  localparam int REG_SECTION    = 7 + REG_COUNT * LINE_BYTES;   // 1095
`ifdef DUMP_MEM_EN
  localparam int TOTAL_BYTES    = 2189;
  localparam int MEM_BUBBLES    = MEM_WORDS;
`else
  localparam int TOTAL_BYTES    = 1095;
  localparam int MEM_BUBBLES    = 0;
`endif
  localparam int CYCLE_BUDGET   = 20000;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [REG_ADDR_WIDTH-1:0] reg_rd_addr;
  logic [DATA_WIDTH-1:0]     reg_rd_data;
  logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0]     mem_rd_data;
  logic [7:0]                tx_byte;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      busy;
  logic                      done;

  dump_controller #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_COUNT     (REG_COUNT),
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .MEM_WORDS     (MEM_WORDS),
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Storage models: combinational register file, synchronous data memory.
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [DATA_WIDTH-1:0] mem  [2**MEM_ADDR_WIDTH];

  assign reg_rd_data = regs[reg_rd_addr];
  always_ff @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         bubble_pos[$];
  bit         saw_done;
  bit         mem_addr_seen;

  // ---------------- reference model: the text the dump should produce -------
  task automatic push_text(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_word(input logic [DATA_WIDTH-1:0] w);
    for (int b = DATA_WIDTH - 1; b >= 0; b--) exp_q.push_back(w[b] ? 8'h31 : 8'h30);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic build_expected();
    exp_q.delete();
    push_text("REGS:");
    for (int r = 0; r < REG_COUNT; r++) push_word(regs[r]);
`ifdef DUMP_MEM_EN
    push_text("MEM:");
    for (int m = 0; m < MEM_WORDS; m++) push_word(mem[m]);
`endif
  endtask

  task automatic randomize_storage();
    for (int r = 0; r < REG_COUNT; r++) regs[r] = $urandom();
    for (int m = 0; m < 2**MEM_ADDR_WIDTH; m++) mem[m] = $urandom();
  endtask

  // Index of the first byte that differs from the model, or -1 if none.
  function automatic int first_diff(input bit prefix_only);
    int n;
    n = (prefix_only || got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
    if (!prefix_only && got.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // ---------------- stimulus helpers -----------------------------------------
  // Leaves the DUT one cycle after it has accepted a fresh start (HDR_REGS).
  task automatic begin_dump();
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drives tx_ready and records every transferred byte until done, until
  // stop_at bytes have been seen, or until the cycle budget runs out.
  // A stalled byte must remain presented unchanged in the next cycle.
  task automatic capture(input bit random_ready, input int stop_at, input int drop_at);
    int         cycles;
    int         drop_left;
    bit         dropped;
    bit         held;
    logic [7:0] held_byte;
    cycles = 0; drop_left = 0; dropped = 0; held = 0; held_byte = 8'h00;
    got.delete();
    bubble_pos.delete();
    saw_done      = 0;
    mem_addr_seen = 0;
    while (1) begin
      if (drop_at >= 0 && !dropped && got.size() >= drop_at) begin
        dropped   = 1;
        drop_left = 5;
      end
      if (drop_left > 0) begin
        tx_ready  = 1'b0;
        drop_left--;
      end else if (random_ready) begin
        tx_ready = ($urandom_range(3) != 0);
      end else begin
        tx_ready = 1'b1;
      end
      @(negedge clk);
      if (held) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_byte !== held_byte) begin
          errors++;
          $display("FAIL hold_stable: byte %0d got valid=%b byte=%h, expected valid=1 byte=%h",
                   got.size(), tx_valid, tx_byte, held_byte);
        end
      end
      held      = (tx_valid === 1'b1) && (tx_ready === 1'b0);
      held_byte = tx_byte;
      if (mem_rd_addr !== '0) mem_addr_seen = 1;
      if (busy === 1'b1 && tx_valid === 1'b0) bubble_pos.push_back(got.size());
      if (tx_valid === 1'b1 && tx_ready === 1'b1) got.push_back(tx_byte);
      if (done === 1'b1) begin
        saw_done = 1;
        break;
      end
      if (stop_at > 0 && got.size() >= stop_at) break;
      cycles++;
      if (cycles >= CYCLE_BUDGET) begin
        checks++;
        errors++;
        $display("FAIL capture_timeout: got %0d bytes after %0d cycles, expected done", got.size(), cycles);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b1;
    tx_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({tx_valid, busy, done, tx_byte, reg_rd_addr, mem_rd_addr} !== '0) begin
        errors++;
        $display("FAIL reset_values: got valid=%b busy=%b done=%b byte=%h raddr=%h maddr=%h, expected all 0",
                 tx_valid, busy, done, tx_byte, reg_rd_addr, mem_rd_addr);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b done=%b, expected 0 0 0", tx_valid, busy, done);
    end
  endtask

  task automatic test_register_line();
    logic [7:0] hdr_exp [7];
    hdr_exp = '{8'h52, 8'h45, 8'h47, 8'h53, 8'h3A, 8'h0D, 8'h0A};
    randomize_storage();
    regs[0] = 32'h8000_0001;
    regs[1] = 32'h8000_0001;
    build_expected();
    begin_dump();
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'h52 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: got valid=%b byte=%h busy=%b, expected 1 52 1", tx_valid, tx_byte, busy);
    end
    capture(0, 0, -1);
    checks++;
    if (!saw_done) begin
      errors++;
      $display("FAIL reg_done: got done never seen, expected done");
    end
    checks++;
    if (got.size() != TOTAL_BYTES) begin
      errors++;
      $display("FAIL reg_total: got %0d bytes, expected %0d", got.size(), TOTAL_BYTES);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== hdr_exp[i]) begin
        errors++;
        $display("FAIL regs_header[%0d]: got %h, expected %h", i, got[i], hdr_exp[i]);
      end
    end
    // x0 and x1 both hold 0x80000001; x0 must not be forced to zero.
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        logic [7:0] want;
        want = (i == 0 || i == 31) ? 8'h31 : (i < 32) ? 8'h30 : (i == 32) ? 8'h0D : 8'h0A;
        checks++;
        if (got[7 + ln * LINE_BYTES + i] !== want) begin
          errors++;
          $display("FAIL reg_line x%0d[%0d]: got %h, expected %h", ln, i, got[7 + ln * LINE_BYTES + i], want);
        end
      end
    end
    checks++;
    if (first_diff(0) != -1) begin
      errors++;
      $display("FAIL reg_stream: got first difference at byte %0d, expected none", first_diff(0));
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_flags: got done=%b busy=%b valid=%b, expected 1 0 0", done, busy, tx_valid);
    end
  endtask

  task automatic test_memory_line();
    logic [7:0] pat;
    pat = 8'hA5;
    randomize_storage();
    mem[1] = 32'hA5A5_A5A5;
    mem[2] = 32'hA5A5_A5A5;
    build_expected();
    begin_dump();
    capture(0, 0, -1);
    checks++;
    if (got.size() != TOTAL_BYTES || !saw_done) begin
      errors++;
      $display("FAIL mem_total: got %0d bytes done=%b, expected %0d bytes done=1", got.size(), saw_done, TOTAL_BYTES);
    end
    checks++;
    if (bubble_pos.size() != MEM_BUBBLES) begin
      errors++;
      $display("FAIL bubble_count: got %0d idle busy cycles, expected %0d", bubble_pos.size(), MEM_BUBBLES);
    end
`ifdef DUMP_MEM_EN
    for (int k = 0; k < bubble_pos.size() && k < MEM_WORDS; k++) begin
      checks++;
      if (bubble_pos[k] != REG_SECTION + 6 + k * LINE_BYTES) begin
        errors++;
        $display("FAIL bubble_pos[%0d]: got after byte %0d, expected after byte %0d",
                 k, bubble_pos[k], REG_SECTION + 6 + k * LINE_BYTES);
      end
    end
    for (int ln = 1; ln < 3; ln++) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        logic [7:0] want;
        int         pos;
        want = (i < 32) ? (pat[7 - (i % 8)] ? 8'h31 : 8'h30) : (i == 32) ? 8'h0D : 8'h0A;
        pos  = REG_SECTION + 6 + ln * LINE_BYTES + i;
        checks++;
        if (got[pos] !== want) begin
          errors++;
          $display("FAIL mem_line%0d[%0d]: got %h, expected %h", ln, i, got[pos], want);
        end
      end
    end
`else
    checks++;
    if (mem_addr_seen) begin
      errors++;
      $display("FAIL mem_addr_tied: got nonzero mem_rd_addr, expected 0");
    end
    checks++;
    if (got[TOTAL_BYTES - 2] !== 8'h0D || got[TOTAL_BYTES - 1] !== 8'h0A) begin
      errors++;
      $display("FAIL last_eol: got %h %h, expected 0d 0a", got[TOTAL_BYTES - 2], got[TOTAL_BYTES - 1]);
    end
`endif
    checks++;
    if (first_diff(0) != -1) begin
      errors++;
      $display("FAIL mem_stream: got first difference at byte %0d, expected none", first_diff(0));
    end
  endtask

  task automatic test_backpressure();
    randomize_storage();
    build_expected();
    begin_dump();
    capture(1, 0, 20);
    checks++;
    if (got.size() != TOTAL_BYTES || !saw_done) begin
      errors++;
      $display("FAIL bp_total: got %0d bytes done=%b, expected %0d bytes done=1", got.size(), saw_done, TOTAL_BYTES);
    end
    checks++;
    if (first_diff(0) != -1) begin
      errors++;
      $display("FAIL bp_stream: got first difference at byte %0d, expected none", first_diff(0));
    end
  endtask

  task automatic test_reset_mid_dump();
    randomize_storage();
    build_expected();
    begin_dump();
    capture(0, 500, -1);
    checks++;
    if (got.size() != 500 || first_diff(1) != -1) begin
      errors++;
      $display("FAIL partial_stream: got %0d bytes first diff %0d, expected 500 bytes no diff",
               got.size(), first_diff(1));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({tx_valid, busy, done, tx_byte, reg_rd_addr, mem_rd_addr} !== '0) begin
      errors++;
      $display("FAIL mid_reset_values: got valid=%b busy=%b done=%b byte=%h raddr=%h maddr=%h, expected all 0",
               tx_valid, busy, done, tx_byte, reg_rd_addr, mem_rd_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'h52) begin
      errors++;
      $display("FAIL restart_first: got valid=%b byte=%h, expected 1 52", tx_valid, tx_byte);
    end
    capture(0, 0, -1);
    checks++;
    if (first_diff(0) != -1 || !saw_done) begin
      errors++;
      $display("FAIL restart_stream: got first diff %0d done=%b, expected none done=1", first_diff(0), saw_done);
    end
  endtask

  task automatic test_one_dump_per_request();
    int extra;
    extra    = 0;
    tx_ready = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || done !== 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL hold_in_done: got %0d cycles with valid or not done, expected 0", extra);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_idle: got done=%b busy=%b valid=%b, expected 0 0 0", done, busy, tx_valid);
    end
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'h52) begin
      errors++;
      $display("FAIL redump_first: got valid=%b byte=%h, expected 1 52", tx_valid, tx_byte);
    end
    build_expected();
    capture(0, 0, -1);
    checks++;
    if (first_diff(0) != -1 || !saw_done) begin
      errors++;
      $display("FAIL redump_stream: got first diff %0d done=%b, expected none done=1", first_diff(0), saw_done);
    end
  endtask

  initial begin
    randomize_storage();
    test_reset();
    test_register_line();
    test_memory_line();
    test_backpressure();
    test_reset_mid_dump();
    test_one_dump_per_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
